pipelined_control_unit: RTL
===========================

Name: pipelined_control_unit

Overview:
- Next-generation control unit for the 16-bit pipelined RISC core.
- Decodes the opcode in ID and carries the control word through ID/EX, EX/MEM and MEM/WB registers.
- Detects load-use hazards and produces stall signals, squashes on a taken branch, and generates EX-stage forwarding selects.
- Parametrised in opcode, register-address and ALU-op widths.

Parameters:
OP_W, 4, opcode width; the decode table uses the low 4 bits, and higher bits must be 0 or the opcode is illegal
RA_W, 3, register address width
ALU_OP_W, 3, ALU operation width (>=3)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
id_valid  in  1  IF/ID holds a valid instruction
id_op  in  OP_W  opcode in ID
id_rs  in  RA_W  source register 1
id_rt  in  RA_W  source register 2 / load destination
id_rd  in  RA_W  R-type destination
br_taken  in  1  datapath branch result for the instruction in MEM; only meaningful when mem_branch=1
pc_write  out  1  0 = hold PC
if_id_write  out  1  0 = hold IF/ID
if_id_flush  out  1  1 = load bubble into IF/ID
id_illegal  out  1  valid instruction with an undefined opcode in ID
ex_alu_op  out  ALU_OP_W  ALU operation in EX
ex_alu_src  out  1  1 = immediate operand
ex_fwd_a  out  2  operand A select: 00 regfile, 10 EX/MEM, 01 MEM/WB
ex_fwd_b  out  2  operand B select, same encoding as ex_fwd_a
mem_read  out  1  MEM-stage load
mem_write  out  1  MEM-stage store
mem_branch  out  1  MEM-stage BNE
wb_reg_write  out  1  WB-stage register write
wb_mem_to_reg  out  1  1 = write-back from memory
wb_dst  out  RA_W  write-back register

Behaviour:
- Decode is combinational in ID; all other fields are zero unless listed:
  - ADD 0010, SUB 0110, AND 0000, OR 0001, SLT 0111: reg_dst=1, reg_write=1, alu_op=op[2:0] zero-extended.
  - LW 1000: alu_src=1, alu_op=010, mem_read=1, mem_to_reg=1, reg_write=1.
  - SW 1010: alu_src=1, alu_op=010, mem_write=1.
  - BNE 1110: branch=1, alu_op=110.
  - Any other opcode: all-zero control word, id_illegal=id_valid.
  - id_valid=0: all-zero control word, id_illegal=0.
- Destination: dst = reg_dst ? rd : rt.
- Source usage: rs is used by all legal opcodes; rt is a source only for R-type, SW and BNE.
- Stage registers: ID/EX -> EX/MEM -> MEM/WB, each holding the remaining control bits plus dst. Each advances every cycle.
- Reset (async, rst_n=0): every stage register is cleared to a bubble.
  - Output values during reset: pc_write=1, if_id_write=1, if_id_flush=0, ex_fwd_a=ex_fwd_b=00, all other outputs 0.
- Load-use stall condition: ID/EX.mem_read=1, ID/EX.dst!=0, and ID/EX.dst matches a used source in ID (id_valid=1).
  - When stalled: pc_write=0, if_id_write=0, and a bubble is loaded into ID/EX next edge.
  - The stall lasts exactly one cycle; forwarding from MEM/WB then resolves the hazard.
- Branch squash: mem_branch=1 and br_taken=1.
  - if_id_flush=1, and bubbles are loaded into ID/EX and EX/MEM next edge.
  - MEM/WB advances normally; BNE writes nothing.
  - pc_write=1, if_id_write=1.
  - Squash has priority over a simultaneous stall, and the stall is dropped.
- br_taken is ignored when mem_branch=0.
- Forwarding, for the EX source register s (rs for A; rt for B, and only if rt is used):
  - 10 if EX/MEM.reg_write=1, EX/MEM.dst!=0 and EX/MEM.dst==s.
  - Otherwise 01 if the same conditions hold for MEM/WB.
  - Otherwise 00. EX/MEM wins when both match.
  - The ID/EX register stores rs, rt and the rt-used flag for this purpose.
- Register 0 never causes a stall or a forward.
- Reset mid-stall or mid-squash: all pipeline state is discarded immediately, with no pending bubble after release.
- Latency: a control bit decoded in ID appears on its ex_*, mem_* or wb_* port 1, 2 or 3 edges later respectively.

Test Plan:
- Reset, then ADD (rs=1, rt=2, rd=3):
  - Edge 1: ex_alu_op=010, ex_alu_src=0.
  - Edge 3: wb_reg_write=1, wb_dst=3, wb_mem_to_reg=0.
- LW r4 then ADD r5=r4+r1:
  - Exactly one cycle with pc_write=0 and if_id_write=0.
  - Bubble in EX; later ADD in EX with ex_fwd_a=01.
- ADD r3, then SUB reading r3 as both sources: ex_fwd_a=ex_fwd_b=10.
  - ADD r3, NOP-equivalent, SUB: ex_fwd_a=ex_fwd_b=01.
- BNE reaches MEM with br_taken=1, and the LW behind it is stalling at the same time:
  - if_id_flush=1, pc_write=1.
  - Next cycle mem_read=0, mem_write=0, ex_alu_op=0.
  - With br_taken=0: no squash.
- Sequence:
  - Opcode 1111 with id_valid=1 gives id_illegal=1 and zero control downstream.
  - LW with rt=0 followed by a dependent ADD on r0 gives no stall and fwd=00.
  - rst_n low mid-stall clears all outputs asynchronously, with no stall after release.

Source files
------------

// File: rtl/pipelined_control_unit_if.sv
// rtl/pipelined_control_unit_if.sv - ID-stage inputs and pipeline control outputs of the control unit
interface pipelined_control_unit_if #(
    parameter int OP_W     = 4,
    parameter int RA_W     = 3,
    parameter int ALU_OP_W = 3
);
    logic                id_valid;
    logic [OP_W-1:0]     id_op;
    logic [RA_W-1:0]     id_rs;
    logic [RA_W-1:0]     id_rt;
    logic [RA_W-1:0]     id_rd;
    logic                br_taken;
    logic                pc_write;
    logic                if_id_write;
    logic                if_id_flush;
    logic                id_illegal;
    logic [ALU_OP_W-1:0] ex_alu_op;
    logic                ex_alu_src;
    logic [1:0]          ex_fwd_a;
    logic [1:0]          ex_fwd_b;
    logic                mem_read;
    logic                mem_write;
    logic                mem_branch;
    logic                wb_reg_write;
    logic                wb_mem_to_reg;
    logic [RA_W-1:0]     wb_dst;

    modport master (
        output id_valid, id_op, id_rs, id_rt, id_rd, br_taken,
        input  pc_write, if_id_write, if_id_flush, id_illegal,
               ex_alu_op, ex_alu_src, ex_fwd_a, ex_fwd_b,
               mem_read, mem_write, mem_branch,
               wb_reg_write, wb_mem_to_reg, wb_dst
    );

    modport slave (
        input  id_valid, id_op, id_rs, id_rt, id_rd, br_taken,
        output pc_write, if_id_write, if_id_flush, id_illegal,
               ex_alu_op, ex_alu_src, ex_fwd_a, ex_fwd_b,
               mem_read, mem_write, mem_branch,
               wb_reg_write, wb_mem_to_reg, wb_dst
    );
endinterface

// File: rtl/pipelined_control_unit.sv
// rtl/pipelined_control_unit.sv - decode, stage control registers, load-use stall, branch squash, forwarding
module pipelined_control_unit #(
    parameter int OP_W     = 4,
    parameter int RA_W     = 3,
    parameter int ALU_OP_W = 3
) (
    input  logic clk,
    input  logic rst_n,
    pipelined_control_unit_if.slave bus
);
    typedef struct packed {
        logic [ALU_OP_W-1:0] alu_op;
        logic                alu_src;
        logic                mem_read;
        logic                mem_write;
        logic                branch;
        logic                reg_write;
        logic                mem_to_reg;
        logic [RA_W-1:0]     dst;
        logic [RA_W-1:0]     rs;
        logic [RA_W-1:0]     rt;
        logic                rt_used;
    } idex_t;

    typedef struct packed {
        logic            mem_read;
        logic            mem_write;
        logic            branch;
        logic            reg_write;
        logic            mem_to_reg;
        logic [RA_W-1:0] dst;
    } exmem_t;

    typedef struct packed {
        logic            reg_write;
        logic            mem_to_reg;
        logic [RA_W-1:0] dst;
    } memwb_t;

    idex_t  dec, idex;
    exmem_t exmem;
    memwb_t memwb;
    logic   dec_legal;
    logic   hi_zero;
    logic   ld_hit;
    logic   squash;
    logic   stall;

    // Illegal or invalid instructions decode to a full bubble, including dst/rs/rt,
    // so they can never trigger a stall or a forward further down.
    always_comb begin
        dec       = '0;
        dec_legal = 1'b0;
        hi_zero   = ((bus.id_op >> 4) == '0);
        if (bus.id_valid && hi_zero) begin
            case (bus.id_op[3:0])
                4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111: begin
                    dec_legal     = 1'b1;
                    dec.alu_op    = ALU_OP_W'(bus.id_op[2:0]);
                    dec.reg_write = 1'b1;
                    dec.dst       = bus.id_rd;
                    dec.rs        = bus.id_rs;
                    dec.rt        = bus.id_rt;
                    dec.rt_used   = 1'b1;
                end
                4'b1000: begin
                    dec_legal      = 1'b1;
                    dec.alu_src    = 1'b1;
                    dec.alu_op     = ALU_OP_W'(3'b010);
                    dec.mem_read   = 1'b1;
                    dec.mem_to_reg = 1'b1;
                    dec.reg_write  = 1'b1;
                    dec.dst        = bus.id_rt;
                    dec.rs         = bus.id_rs;
                end
                4'b1010: begin
                    dec_legal     = 1'b1;
                    dec.alu_src   = 1'b1;
                    dec.alu_op    = ALU_OP_W'(3'b010);
                    dec.mem_write = 1'b1;
                    dec.dst       = bus.id_rt;
                    dec.rs        = bus.id_rs;
                    dec.rt        = bus.id_rt;
                    dec.rt_used   = 1'b1;
                end
                4'b1110: begin
                    dec_legal   = 1'b1;
                    dec.branch  = 1'b1;
                    dec.alu_op  = ALU_OP_W'(3'b110);
                    dec.dst     = bus.id_rt;
                    dec.rs      = bus.id_rs;
                    dec.rt      = bus.id_rt;
                    dec.rt_used = 1'b1;
                end
                default: dec_legal = 1'b0;
            endcase
        end
    end

    always_comb begin
        ld_hit = idex.mem_read && (idex.dst != '0) &&
                 ((dec_legal && (idex.dst == bus.id_rs)) ||
                  (dec.rt_used && (idex.dst == bus.id_rt)));
        squash = exmem.branch && bus.br_taken;
        stall  = ld_hit && !squash;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idex  <= '0;
            exmem <= '0;
            memwb <= '0;
        end else begin
            idex  <= (stall || squash) ? '0 : dec;
            exmem <= squash ? '0 : exmem_t'{idex.mem_read, idex.mem_write, idex.branch,
                                             idex.reg_write, idex.mem_to_reg, idex.dst};
            memwb <= memwb_t'{exmem.reg_write, exmem.mem_to_reg, exmem.dst};
        end
    end

    function automatic logic [1:0] fwd_sel(input logic [RA_W-1:0] src, input logic used);
        if (!used || src == '0)                              return 2'b00;
        else if (exmem.reg_write && exmem.dst == src)        return 2'b10;
        else if (memwb.reg_write && memwb.dst == src)        return 2'b01;
        else                                                 return 2'b00;
    endfunction

    assign bus.pc_write      = !stall;
    assign bus.if_id_write   = !stall;
    assign bus.if_id_flush   = squash;
    assign bus.id_illegal    = rst_n && bus.id_valid && !dec_legal;
    assign bus.ex_alu_op     = idex.alu_op;
    assign bus.ex_alu_src    = idex.alu_src;
    assign bus.ex_fwd_a      = fwd_sel(idex.rs, 1'b1);
    assign bus.ex_fwd_b      = fwd_sel(idex.rt, idex.rt_used);
    assign bus.mem_read      = exmem.mem_read;
    assign bus.mem_write     = exmem.mem_write;
    assign bus.mem_branch    = exmem.branch;
    assign bus.wb_reg_write  = memwb.reg_write;
    assign bus.wb_mem_to_reg = memwb.mem_to_reg;
    assign bus.wb_dst        = memwb.dst;
endmodule
